// File: rtl/motor_pkg.sv
// Shared definitions for the motor_controller register map and the speed-loop scheduler.
package motor_pkg;

    localparam logic [31:0] MC_CTRL_OFS = 32'h00;
    localparam logic [31:0] MC_POS_OFS  = 32'h10;
    localparam int          MC_EN_BIT   = 31;
    localparam int          MC_DIR_BIT  = 30;
    localparam int          MC_DUTY_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_POS,
        ST_CALC,
        ST_WR_CTL,
        ST_NEXT
    } loop_state_t;

endpackage

// File: rtl/motor_loop_math.sv
// Combinational velocity / integral-law datapath for one motor; shared across motors by the scheduler.
module motor_loop_math
    import motor_pkg::*;
#(
    parameter int KP_SHIFT = 4
) (
    input  logic [31:0] pos,
    input  logic [31:0] prev,
    input  logic [15:0] target,
    input  logic [8:0]  u_cur,
    output logic [15:0] vel,
    output logic [8:0]  u_next,
    output logic        dir,
    output logic [7:0]  cmp
);
    localparam logic signed [17:0] U_MAX = 18'(MC_DUTY_MAX);

    logic signed [31:0] delta;
    logic signed [15:0] vel_sat;
    logic signed [16:0] err;
    logic signed [16:0] err_shr;
    logic signed [17:0] u_sum;
    logic signed [8:0]  u_sat;

    always_comb begin
        // Modular difference handles encoder wrap; then clamp to the 16-bit velocity range.
        delta = $signed(pos - prev);
        if (delta > 32'sd32767) begin
            vel_sat = 16'sh7FFF;
        end else if (delta < -32'sd32768) begin
            vel_sat = 16'sh8000;
        end else begin
            vel_sat = delta[15:0];
        end

        err     = $signed({target[15], target}) - $signed({vel_sat[15], vel_sat});
        err_shr = err >>> KP_SHIFT;
        u_sum   = $signed({{9{u_cur[8]}}, u_cur}) + $signed({err_shr[16], err_shr});

        if (u_sum > U_MAX) begin
            u_sat = 9'(U_MAX);
        end else if (u_sum < -U_MAX) begin
            u_sat = 9'(-U_MAX);
        end else begin
            u_sat = u_sum[8:0];
        end
    end

    assign vel    = vel_sat;
    assign u_next = u_sat;
    assign dir    = u_sat[8];
    assign cmp    = 8'(u_sat[8] ? -u_sat : u_sat);

endmodule

// File: rtl/motor_speed_loop.sv
// Periodic Wishbone-master scheduler: reads each encoder, runs the integral speed law and
// writes enable/direction/PWM back to motor_controller.
module motor_speed_loop
    import motor_pkg::*;
#(
    parameter int          COUNT     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          PERIOD    = 50000,
    parameter int          KP_SHIFT  = 4,
    parameter int          TIMEOUT   = 64
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                loop_en,
    input  logic [16*COUNT-1:0] target_vel,
    input  logic                clr_status,
    output logic [16*COUNT-1:0] vel,
    output logic                busy,
    output logic                overrun,
    output logic                bus_err,
    output logic                wbm_cyc,
    output logic                wbm_stb,
    output logic                wbm_we,
    output logic [31:0]         wbm_adr,
    output logic [3:0]          wbm_sel,
    output logic [31:0]         wbm_mosi,
    input  logic [31:0]         wbm_miso,
    input  logic                wbm_ack,
    input  logic                wbm_err
);
    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int PRE_W = $clog2(PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    loop_state_t      state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic [31:0]      pos_reg;
    logic [31:0]      ctl_reg;
    logic [31:0]      ctl_word;
    logic             overrun_reg, bus_err_reg;
    logic             tick, xfer, xfer_ok, xfer_fail;

    logic [31:0] prev_arr   [COUNT];
    logic [8:0]  u_arr      [COUNT];
    logic        primed_arr [COUNT];
    logic [15:0] target_arr [COUNT];

    logic [15:0] math_vel;
    logic [8:0]  math_u_next;
    logic        math_dir;
    logic [7:0]  math_cmp;

    assign tick      = (pre_reg == PRE_LAST);
    assign busy      = (state_reg != ST_IDLE);
    assign xfer      = (state_reg == ST_RD_POS) || (state_reg == ST_WR_CTL);
    assign xfer_ok   = xfer && wbm_ack && !wbm_err;
    assign xfer_fail = xfer && (wbm_err || (!wbm_ack && tmo_reg == TMO_LAST));
    assign overrun   = overrun_reg;
    assign bus_err   = bus_err_reg;

    for (genvar gi = 0; gi < COUNT; gi++) begin : g_motor
        logic [31:0] prev_reg;
        logic [8:0]  u_reg;
        logic        primed_reg;
        logic [15:0] vel_reg;
        logic        calc_this;

        assign calc_this = (state_reg == ST_CALC) && (idx_reg == IDX_W'(gi));

        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                prev_reg   <= '0;
                u_reg      <= '0;
                primed_reg <= 1'b0;
                vel_reg    <= '0;
            end else if (calc_this) begin
                if (!loop_en) begin
                    u_reg      <= '0;
                    primed_reg <= 1'b0;
                end else if (!primed_reg) begin
                    prev_reg   <= pos_reg;
                    primed_reg <= 1'b1;
                end else begin
                    prev_reg <= pos_reg;
                    u_reg    <= math_u_next;
                    vel_reg  <= math_vel;
                end
            end
        end

        assign prev_arr[gi]       = prev_reg;
        assign u_arr[gi]          = u_reg;
        assign primed_arr[gi]     = primed_reg;
        assign target_arr[gi]     = target_vel[16*gi +: 16];
        assign vel[16*gi +: 16]   = vel_reg;
    end

    motor_loop_math #(
        .KP_SHIFT (KP_SHIFT)
    ) u_math (
        .pos    (pos_reg),
        .prev   (prev_arr[idx_reg]),
        .target (target_arr[idx_reg]),
        .u_cur  (u_arr[idx_reg]),
        .vel    (math_vel),
        .u_next (math_u_next),
        .dir    (math_dir),
        .cmp    (math_cmp)
    );

    always_comb begin
        ctl_word = '0;
        if (loop_en) begin
            ctl_word[MC_EN_BIT]  = (math_u_next != '0);
            ctl_word[MC_DIR_BIT] = math_dir;
            ctl_word[7:0]        = math_cmp;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            pre_reg     <= '0;
            tmo_reg     <= '0;
            pos_reg     <= '0;
            ctl_reg     <= '0;
            overrun_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pre_reg   <= tick ? '0 : pre_reg + PRE_W'(1);
            tmo_reg   <= (xfer && state_next == state_reg) ? tmo_reg + TMO_W'(1) : '0;
            if (state_reg == ST_IDLE && tick) begin
                idx_reg <= '0;
            end else if (state_reg == ST_NEXT && idx_reg != IDX_LAST) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
            if (state_reg == ST_RD_POS && xfer_ok) begin
                pos_reg <= wbm_miso;
            end
            if (state_reg == ST_CALC) begin
                ctl_reg <= ctl_word;
            end
            // Set beats clear when both happen in the same cycle.
            if (tick && busy) begin
                overrun_reg <= 1'b1;
            end else if (clr_status) begin
                overrun_reg <= 1'b0;
            end
            if (xfer_fail) begin
                bus_err_reg <= 1'b1;
            end else if (clr_status) begin
                bus_err_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (tick) state_next = ST_RD_POS;
            ST_RD_POS: begin
                if (xfer_ok) begin
                    state_next = ST_CALC;
                end else if (xfer_fail) begin
                    state_next = ST_NEXT;
                end
            end
            ST_CALC:   state_next = (loop_en && !primed_arr[idx_reg]) ? ST_NEXT : ST_WR_CTL;
            ST_WR_CTL: if (xfer_ok || xfer_fail) state_next = ST_NEXT;
            ST_NEXT:   state_next = (idx_reg == IDX_LAST) ? ST_IDLE : ST_RD_POS;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register so reset drops them without a clock.
    always_comb begin
        wbm_cyc  = 1'b0;
        wbm_stb  = 1'b0;
        wbm_we   = 1'b0;
        wbm_adr  = '0;
        wbm_sel  = '0;
        wbm_mosi = '0;
        case (state_reg)
            ST_RD_POS: begin
                wbm_cyc = 1'b1;
                wbm_stb = 1'b1;
                wbm_adr = BASE_ADDR + MC_POS_OFS + (32'(idx_reg) << 2);
                wbm_sel = 4'b1111;
            end
            ST_WR_CTL: begin
                wbm_cyc  = 1'b1;
                wbm_stb  = 1'b1;
                wbm_we   = 1'b1;
                wbm_adr  = BASE_ADDR + MC_CTRL_OFS + (32'(idx_reg) << 2);
                wbm_sel  = 4'b1001;
                wbm_mosi = ctl_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_motor_speed_loop.sv
// Directed bench for motor_speed_loop with a small Wishbone slave model (position memory, wait states, err, stall).
module tb_motor_speed_loop;
    localparam int COUNT = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        loop_en = 1'b0;
    logic        clr_status = 1'b0;
    logic [63:0] target_vel = '0;
    logic [63:0] vel;
    logic        busy, overrun, bus_err;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [31:0] wbm_adr, wbm_mosi, wbm_miso;
    logic [3:0]  wbm_sel;
    logic        wbm_ack, wbm_err;

    motor_speed_loop #(
        .COUNT (COUNT), .BASE_ADDR (32'h0), .PERIOD (40), .KP_SHIFT (4), .TIMEOUT (64)
    ) dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .loop_en (loop_en),
        .target_vel (target_vel), .clr_status (clr_status), .vel (vel),
        .busy (busy), .overrun (overrun), .bus_err (bus_err),
        .wbm_cyc (wbm_cyc), .wbm_stb (wbm_stb), .wbm_we (wbm_we),
        .wbm_adr (wbm_adr), .wbm_sel (wbm_sel), .wbm_mosi (wbm_mosi),
        .wbm_miso (wbm_miso), .wbm_ack (wbm_ack), .wbm_err (wbm_err)
    );

    always #5 sys_clk = ~sys_clk;

    logic [31:0] pos_mem [4];
    int          wait_states = 0;
    bit          stall = 1'b0;
    logic [31:0] err_adr = 32'hFFFF_FFFF;
    int          wcnt;
    int          rd_n = 0;
    int          wr_n = 0;
    logic [31:0] wr_adr [1024];
    logic [31:0] wr_dat [1024];
    logic [3:0]  wr_sel [1024];

    assign wbm_miso = (wbm_adr[31:4] == 28'h1) ? pos_mem[wbm_adr[3:2]] : 32'h0;

    always @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wbm_ack <= 1'b0;
            wbm_err <= 1'b0;
            wcnt    <= 0;
        end else if (wbm_cyc && wbm_stb) begin
            if (wbm_ack && !wbm_err) begin
                if (wbm_we) begin
                    if (wr_n < 1024) begin
                        wr_adr[wr_n] <= wbm_adr;
                        wr_dat[wr_n] <= wbm_mosi;
                        wr_sel[wr_n] <= wbm_sel;
                    end
                    wr_n <= wr_n + 1;
                end else begin
                    rd_n <= rd_n + 1;
                end
            end
            wcnt <= wcnt + 1;
            if (!stall && wcnt >= wait_states) begin
                if (wbm_adr == err_adr) wbm_err <= 1'b1;
                else                    wbm_ack <= 1'b1;
            end
        end else begin
            wbm_ack <= 1'b0;
            wbm_err <= 1'b0;
            wcnt    <= 0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_pass(output int bcyc);
        int t;
        t = 0;
        bcyc = 0;
        while (busy !== 1'b1 && t < 400) begin @(negedge sys_clk); t++; end
        check("pass_start", {31'd0, busy}, 32'd1);
        while (busy === 1'b1 && t < 1000) begin bcyc++; @(negedge sys_clk); t++; end
        check("pass_end", {31'd0, busy}, 32'd0);
        $display("pass done: busy_cycles=%0d reads=%0d writes=%0d", bcyc, rd_n, wr_n);
    endtask

    function automatic int count_wr(input int w0, input logic [31:0] adr);
        int n;
        n = 0;
        for (int k = w0; k < wr_n && k < 1024; k++) if (wr_adr[k] == adr) n++;
        return n;
    endfunction

    task automatic check_wr(input string tag, input int w0, input logic [31:0] adr, input logic [31:0] dat);
        logic        found;
        logic [31:0] d;
        logic [3:0]  s;
        found = 1'b0;
        d = 32'hDEAD_BEEF;
        s = 4'h0;
        for (int k = w0; k < wr_n && k < 1024; k++) begin
            if (wr_adr[k] == adr) begin found = 1'b1; d = wr_dat[k]; s = wr_sel[k]; end
        end
        check({tag, "_seen"}, {31'd0, found}, 32'd1);
        check({tag, "_data"}, d, dat);
        check({tag, "_sel"}, {28'd0, s}, 32'h9);
    endtask

    task automatic pulse_clr();
        @(negedge sys_clk); clr_status = 1'b1;
        @(negedge sys_clk); clr_status = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, w0, r0, n, t;
        for (int i = 0; i < 4; i++) pos_mem[i] = 32'd100;
        repeat (3) @(negedge sys_clk);
        check("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
        check("rst_stb", {31'd0, wbm_stb}, 32'd0);
        check("rst_adr", wbm_adr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, overrun, bus_err}, 32'd0);
        check("rst_vel_lo", vel[31:0], 32'd0);
        check("rst_vel_hi", vel[63:32], 32'd0);
        sys_rst = 1'b1;
        loop_en = 1'b1;

        // Priming: first pass reads only, second pass writes zero everywhere.
        w0 = wr_n; r0 = rd_n; run_pass(bc);
        check("prime1_reads", 32'(rd_n - r0), 32'd4);
        check("prime1_writes", 32'(wr_n - w0), 32'd0);
        w0 = wr_n; r0 = rd_n; run_pass(bc);
        check("prime2_reads", 32'(rd_n - r0), 32'd4);
        check("prime2_writes", 32'(wr_n - w0), 32'd4);
        check("prime2_busy", 32'(bc), 32'd24);
        for (int i = 0; i < 4; i++) check_wr("prime2_wr", w0, 32'(4 * i), 32'h0);
        check("prime2_vel0", {16'd0, vel[15:0]}, 32'd0);

        // Integration: +64 target gives +4 per pass, saturating at 255.
        target_vel[15:0] = 16'd64;
        w0 = wr_n; run_pass(bc); check_wr("int_p1", w0, 32'h0, 32'h8000_0004);
        check_wr("int_m1", w0, 32'h4, 32'h0);
        w0 = wr_n; run_pass(bc); check_wr("int_p2", w0, 32'h0, 32'h8000_0008);
        for (int p = 0; p < 60; p++) run_pass(bc);
        w0 = wr_n; run_pass(bc); check_wr("int_p63", w0, 32'h0, 32'h8000_00FC);
        w0 = wr_n; run_pass(bc); check_wr("int_sat", w0, 32'h0, 32'h8000_00FF);
        target_vel[15:0] = 16'hFFC0;
        w0 = wr_n; run_pass(bc); check_wr("int_neg1", w0, 32'h0, 32'h8000_00FB);
        target_vel[15:0] = 16'h8000;
        w0 = wr_n; run_pass(bc); check_wr("int_negsat", w0, 32'h0, 32'hC000_00FF);
        target_vel[15:0] = 16'h0000;

        // Position wrap and velocity saturation.
        pos_mem[0] = 32'hFFFF_FFF0; run_pass(bc);
        check("wrap_vel_a", {16'd0, vel[15:0]}, 32'h0000_FF8C);
        pos_mem[0] = 32'h0000_0010; run_pass(bc);
        check("wrap_vel_b", {16'd0, vel[15:0]}, 32'h0000_0020);
        pos_mem[0] = 32'h0010_0010; run_pass(bc);
        check("vel_sat_pos", {16'd0, vel[15:0]}, 32'h0000_7FFF);
        pos_mem[0] = 32'h0000_0010; run_pass(bc);
        check("vel_sat_neg", {16'd0, vel[15:0]}, 32'h0000_8000);
        check("vel1_static", {16'd0, vel[31:16]}, 32'd0);

        // Error on motor 2's position read.
        err_adr = 32'h18;
        w0 = wr_n; r0 = rd_n; run_pass(bc);
        check("berr_flag", {31'd0, bus_err}, 32'd1);
        check("berr_writes", 32'(wr_n - w0), 32'd3);
        check("berr_reads", 32'(rd_n - r0), 32'd3);
        check("berr_no_m2", 32'(count_wr(w0, 32'h8)), 32'd0);
        check_wr("berr_m3", w0, 32'hC, 32'h0);
        check_wr("berr_m0", w0, 32'h0, 32'h8000_00FF);
        check("berr_no_overrun", {31'd0, overrun}, 32'd0);
        err_adr = 32'hFFFF_FFFF;
        pulse_clr();
        check("berr_cleared", {31'd0, bus_err}, 32'd0);

        // Stalled slave: 64 strobe cycles, then abandon.
        stall = 1'b1;
        t = 0;
        while (wbm_stb !== 1'b1 && t < 200) begin @(negedge sys_clk); t++; end
        n = 0;
        while (wbm_stb === 1'b1 && n < 200) begin n++; @(negedge sys_clk); end
        stall = 1'b0;
        check("tmo_cycles", 32'(n), 32'd64);
        check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
        check("tmo_cyc_low", {31'd0, wbm_cyc}, 32'd0);
        t = 0;
        while (busy === 1'b1 && t < 400) begin @(negedge sys_clk); t++; end
        check("tmo_overrun", {31'd0, overrun}, 32'd1);
        pulse_clr();
        check("tmo_cleared", {30'd0, overrun, bus_err}, 32'd0);

        // Slow slave: pass outlasts the 40-cycle period.
        wait_states = 3;
        run_pass(bc);
        check("slow_busy", 32'(bc), 32'd48);
        check("slow_overrun", {31'd0, overrun}, 32'd1);
        wait_states = 0;
        pulse_clr();
        check("slow_cleared", {31'd0, overrun}, 32'd0);

        // Disable pass writes zero to every motor; re-enable re-primes.
        loop_en = 1'b0;
        w0 = wr_n; run_pass(bc);
        check("dis_writes", 32'(wr_n - w0), 32'd4);
        for (int i = 0; i < 4; i++) check_wr("dis_wr", w0, 32'(4 * i), 32'h0);
        loop_en = 1'b1;
        w0 = wr_n; run_pass(bc);
        check("reprime_writes", 32'(wr_n - w0), 32'd0);

        // Asynchronous reset during a control write.
        t = 0;
        while (!(wbm_we === 1'b1 && wbm_stb === 1'b1) && t < 400) begin @(negedge sys_clk); t++; end
        check("mid_wr_seen", {31'd0, wbm_we}, 32'd1);
        #1 sys_rst = 1'b0;
        #1;
        check("arst_cyc", {31'd0, wbm_cyc}, 32'd0);
        check("arst_stb", {31'd0, wbm_stb}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_vel", vel[31:0], 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
